rr_mux_arbiter: RTL and testbench

Parametrised N-channel registered multiplexer with per-channel valid/ready handshake. Selection is made by an internal arbiter, not by a select input. The arbiter runs either round-robin or fixed-priority. The block funnels NUM_CH producer streams into one consumer stream and reports the source channel index with each word, replacing the fixed combinational 8:1 selectors in datapaths that need back-pressure.

---
 rtl/rr_mux_arbiter_pkg.sv | 19 +
 rtl/rr_mux_arbiter_picker.sv | 64 ++++++
 rtl/rr_mux_arbiter.sv | 94 +++++++++
 tb/tb_rr_mux_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_picker.sv
// Combinational requester picker: finds the first request at or after a start
// index, wrapping around, by masking a doubled copy of the request vector.
module rr_priority_picker
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    localparam int unsigned CH_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_ch,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any_grant
);

    localparam int unsigned DBL_W = 2 * NUM_CH;

    logic [CH_W-1:0]  start;
    logic [DBL_W-1:0] dbl_req;
    logic [DBL_W-1:0] masked;
    logic             found;
    int unsigned      first_pos;
    int unsigned      idx;

    always_comb begin
        if (mode) begin
            start = '0;
        end else if (last_ch >= CH_W'(NUM_CH - 1)) begin
            start = '0;
        end else begin
            start = last_ch + 1'b1;
        end
    end

    // Upper copy holds every request, so a hit below start in the lower copy
    // is found there after the wrap.
    always_comb begin
        dbl_req = {req, req};
        masked  = dbl_req & ({DBL_W{1'b1}} << start);
    end

    always_comb begin
        found     = 1'b0;
        first_pos = 0;
        for (int unsigned j = 0; j < DBL_W; j++) begin
            if (masked[j] && !found) begin
                found     = 1'b1;
                first_pos = j;
            end
        end
        idx = (first_pos >= NUM_CH) ? first_pos - NUM_CH : first_pos;
    end

    always_comb begin
        any_grant = found;
        grant_idx = CH_W'(idx);
        grant     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            grant[i] = found && (idx == i);
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// NUM_CH-to-1 registered mux with valid/ready on every side; an internal
// arbiter (round-robin or fixed priority) chooses the source channel.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MODE   = MODE_RR,
    localparam int unsigned CH_W  = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_grant;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    rr_priority_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req       (in_valid),
        .last_ch   (last_ch_q),
        .mode      (MODE == MODE_FIXED),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output slot is free when empty or being drained this cycle.
    assign load     = ~out_valid_q | out_ready;
    assign xfer     = load & any_grant & ~rst;
    assign in_ready = (load && !rst) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_ch_d   = last_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
            if (MODE == MODE_RR) begin
                last_ch_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_ch_q   <= CH_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_ch_q   <= last_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: three arbiter instances (8ch RR, 8ch fixed, 5ch RR) share stimulus.
module tb_rr_mux_arbiter;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vld;
    logic [63:0] dat;
    logic        ordy;

    logic [7:0] rdy_a, rdy_b;
    logic [4:0] rdy_c;
    logic       ov_a, ov_b, ov_c;
    logic [7:0] od_a, od_b, od_c;
    logic [2:0] oc_a, oc_b, oc_c;

    logic [7:0] rdy [3];
    logic       ov  [3];
    logic [7:0] od  [3];
    logic [2:0] oc  [3];

    assign rdy[0] = rdy_a;
    assign rdy[1] = rdy_b;
    assign rdy[2] = {3'b000, rdy_c};
    assign ov[0] = ov_a;
    assign ov[1] = ov_b;
    assign ov[2] = ov_c;
    assign od[0] = od_a;
    assign od[1] = od_b;
    assign od[2] = od_c;
    assign oc[0] = oc_a;
    assign oc[1] = oc_b;
    assign oc[2] = oc_c;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.NUM_CH(8), .DATA_W(8), .MODE(0)) u_rr8 (
        .clk(clk), .rst(rst), .in_valid(vld), .in_data(dat), .in_ready(rdy_a),
        .out_valid(ov_a), .out_data(od_a), .out_ch(oc_a), .out_ready(ordy)
    );

    rr_mux_arbiter #(.NUM_CH(8), .DATA_W(8), .MODE(1)) u_fix8 (
        .clk(clk), .rst(rst), .in_valid(vld), .in_data(dat), .in_ready(rdy_b),
        .out_valid(ov_b), .out_data(od_b), .out_ch(oc_b), .out_ready(ordy)
    );

    rr_mux_arbiter #(.NUM_CH(5), .DATA_W(8), .MODE(0)) u_rr5 (
        .clk(clk), .rst(rst), .in_valid(vld[4:0]), .in_data(dat[39:0]), .in_ready(rdy_c),
        .out_valid(ov_c), .out_data(od_c), .out_ch(oc_c), .out_ready(ordy)
    );

    word_t q0[$], q1[$], q2[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int  mlast  [3];
    bit  mvalid [3];

    function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endfunction

    function automatic void qpush(int k, word_t w);
        case (k)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endfunction

    function automatic void qclear(int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endfunction

    function automatic int qsize(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic word_t qpop(int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Reference: scan channels in priority order starting after the last winner.
    function automatic void model_step();
        int         n;
        bit         fixed;
        int         start;
        int         g;
        int         c;
        bit         found;
        logic [7:0] e;
        word_t      w;
        for (int k = 0; k < 3; k++) begin
            n     = (k == 2) ? 5 : 8;
            fixed = (k == 1);
            check("out_valid", k, 32'(ov[k]), 32'(mvalid[k]));
            found = 1'b0;
            g     = 0;
            e     = '0;
            start = fixed ? 0 : (mlast[k] + 1) % n;
            for (int s = 0; s < n; s++) begin
                c = (start + s) % n;
                if (!found && vld[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            if (!rst && found && (!mvalid[k] || ordy)) e[g] = 1'b1;
            check("in_ready", k, 32'(rdy[k]), 32'(e));
            if (rst) begin
                mvalid[k] = 1'b0;
                mlast[k]  = n - 1;
                qclear(k);
            end else if (e != 0) begin
                w.ch   = 3'(g);
                w.data = dat[g*8 +: 8];
                qpush(k, w);
                mvalid[k] = 1'b1;
                if (!fixed) mlast[k] = g;
            end else if (ordy) begin
                mvalid[k] = 1'b0;
            end
        end
    endfunction

    task automatic cycle(input logic r, input logic [7:0] v, input logic o, input logic [63:0] d);
        @(negedge clk);
        rst  = r;
        vld  = v;
        ordy = o;
        dat  = d;
        #1;
        model_step();
    endtask

    task automatic chk_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", k, 32'(ov[k]), 32'd0);
            check("rst_data", k, 32'(od[k]), 32'd0);
            check("rst_ch", k, 32'(oc[k]), 32'd0);
        end
    endtask

    // Monitor: pops the expected word whenever the consumer takes one.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ordy) begin
                for (int k = 0; k < 3; k++) begin
                    if (ov[k]) begin
                        if (qsize(k) == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_word dut%0d: got ch %0d data %0h expected none", k, oc[k], od[k]);
                        end else begin
                            w = qpop(k);
                            check("out_ch", k, 32'(oc[k]), 32'(w.ch));
                            check("out_data", k, 32'(od[k]), 32'(w.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] inc;
        logic [7:0]  v;
        logic        o;
        logic        r;
        rst  = 1'b1;
        vld  = '0;
        ordy = 1'b0;
        dat  = '0;
        mlast[0] = 7;
        mlast[1] = 7;
        mlast[2] = 4;
        for (int k = 0; k < 3; k++) mvalid[k] = 1'b0;
        for (int i = 0; i < 8; i++) inc[i*8 +: 8] = 8'h10 + 8'(i);

        cycle(1'b1, 8'h00, 1'b0, inc);
        cycle(1'b1, 8'h00, 1'b0, inc);
        chk_reset();

        repeat (10) cycle(1'b0, 8'hFF, 1'b1, inc);
        repeat (3) cycle(1'b0, 8'hA4, 1'b1, inc);
        repeat (3) cycle(1'b0, 8'hA0, 1'b1, inc);
        repeat (3) cycle(1'b0, 8'h80, 1'b1, inc);
        repeat (4) cycle(1'b0, 8'hFF, 1'b0, inc);
        repeat (3) cycle(1'b0, 8'hFF, 1'b1, inc);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, inc);
        repeat (4) cycle(1'b0, 8'h41, 1'b1, inc);
        repeat (2) cycle(1'b0, 8'hFF, 1'b0, inc);
        cycle(1'b1, 8'hFF, 1'b0, inc);
        chk_reset();
        repeat (3) cycle(1'b0, 8'hFF, 1'b1, inc);

        repeat (400) begin
            v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            o = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 99) == 0);
            cycle(r, v, o, {$urandom, $urandom});
        end

        repeat (3) cycle(1'b0, 8'h00, 1'b1, inc);
        @(negedge clk);
        #3;
        for (int k = 0; k < 3; k++) check("queue_left", k, 32'(qsize(k)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
